// File: rtl/temp_uart_reporter.sv
// temp_uart_reporter: snapshots a BCD temperature on valid and sends "+HTO.F\r\n" over UART TX (8N1, LSB first)
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   valid               one-cycle pulse, new temperature available (accepted only while not busy)
//   sign, hundreds, tens, ones, fractional   temperature sign and BCD digits
//   tx                  UART serial output, idle high
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last stop bit of a frame
//   overrun             sticky, set when valid arrives while busy
module temp_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       sign,
  input  logic [3:0] fractional,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [2:0]  idx_q;
  logic        sign_q;
  logic [3:0]  h_q;
  logic [3:0]  t_q;
  logic [3:0]  o_q;
  logic [3:0]  f_q;
  logic [7:0]  ch;
  logic        bit_end;
  function automatic logic [7:0] enc(input logic [3:0] d);
    return d > 4'd9 ? 8'h3F : {4'h3, d};
  endfunction
  // Character currently being serialised, selected by the character index.
  always_comb begin
    ch = idx_q == 3'd0 ? (sign_q ? 8'h2D : 8'h2B) :
         idx_q == 3'd1 ? enc(h_q) :
         idx_q == 3'd2 ? enc(t_q) :
         idx_q == 3'd3 ? enc(o_q) :
         idx_q == 3'd4 ? 8'h2E :
         idx_q == 3'd5 ? enc(f_q) :
         idx_q == 3'd6 ? 8'h0D : 8'h0A;
    bit_end = cnt_q == LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      sign_q     <= 1'b0;
      h_q        <= '0;
      t_q        <= '0;
      o_q        <= '0;
      f_q        <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (valid && busy) overrun <= 1'b1;
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
      case (state_q)
        IDLE: if (valid) begin
          state_q <= START_BIT;
          busy    <= 1'b1;
          tx      <= 1'b0;
          idx_q   <= '0;
          sign_q  <= sign;
          h_q     <= hundreds;
          t_q     <= tens;
          o_q     <= ones;
          f_q     <= fractional;
        end
        START_BIT: if (bit_end) begin
          state_q <= DATA_BITS;
          bit_q   <= '0;
          tx      <= ch[0];
        end
        DATA_BITS: if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_q <= STOP_BIT;
            tx      <= 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx    <= ch[bit_q + 3'd1];
          end
        end
        STOP_BIT: if (bit_end) begin
          // The next start bit follows the stop bit directly, with no idle gap.
          if (idx_q == 3'd7) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            state_q <= START_BIT;
            idx_q   <= idx_q + 3'd1;
            tx      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/temp_uart_reporter.md
Name: temp_uart_reporter

Overview:
Downstream consumer of the LM75A driver's BCD temperature outputs. On each driver `valid` pulse it snapshots sign and BCD digits, formats an 8-character ASCII line "+HTO.F\r\n", and transmits it on a UART TX line (8N1, LSB first). This gives a host PC a once-per-read temperature log.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535, counter 16 bits wide.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
valid  input  1  one-cycle pulse: new temperature available
sign  input  1  0: positive, 1: negative
fractional  input  4  BCD tenths digit
ones  input  4  BCD ones digit
tens  input  4  BCD tens digit
hundreds  input  4  BCD hundreds digit
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last stop bit completes
overrun  output  1  sticky: valid arrived while busy

Behaviour:
- Reset values (synchronous, on `rst` high at a clk edge): tx=1, busy=0, frame_done=0, overrun=0, state IDLE, all counters 0. Reset mid-frame aborts the frame; tx=1 from the following cycle.
- Accept rule: `valid` is sampled only when busy=0. On acceptance, latch sign/hundreds/tens/ones/fractional into a snapshot register. Input changes after acceptance do not affect the frame.
- Latency: busy=1 and tx=0 (start bit) from the edge after the valid cycle.
- Character order (index 0..7):
  - 0: sign, '+' 0x2B or '-' 0x2D
  - 1: hundreds
  - 2: tens
  - 3: ones
  - 4: '.' 0x2E
  - 5: fractional
  - 6: CR 0x0D
  - 7: LF 0x0A
- Digit encoding: digit d in 0..9 maps to 0x30+d. d>9 maps to '?' 0x3F. Leading zeros are not suppressed.
- States: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT.
  - From STOP_BIT: to START_BIT of the next character if index<7, else to IDLE.
  - No gap between characters.
- Bit timing:
  - Each start, data and stop bit holds exactly CLKS_PER_BIT cycles.
  - The bit counter counts 0..CLKS_PER_BIT-1; the transition happens on the count CLKS_PER_BIT-1.
  - Data bits go LSB first; a 3-bit index counts 0..7.
- Frame length: 80*CLKS_PER_BIT cycles from the first tx=0 to the end of the final stop bit.
- End of frame: on the edge that ends the last stop bit, busy<=0 and frame_done<=1 for one cycle, and tx stays 1. A valid in that same cycle (busy=0) is accepted, and its start bit follows on the next edge.
- Overrun: valid with busy=1 sets overrun=1. The frame in progress continues unaffected and the new sample is dropped. overrun clears only on rst.
- busy and tx are registered outputs (no combinational path from valid).

Test Plan:
1. CLKS_PER_BIT=4. Pulse valid with sign=0, H=0, T=2, O=5, F=5 -> tx carries bytes 2B 30 32 35 2E 35 0D 0A. Each bit lasts 4 cycles, busy stays high 320 cycles, and frame_done pulses once.
2. sign=1, H=0, T=1, O=0, F=0 -> bytes 2D 30 31 30 2E 30 0D 0A. Changing the inputs during the frame does not alter the bytes sent.
3. A second valid at cycle 100 of a frame -> the frame is unchanged, overrun=1 and stays 1. No second frame is sent.
4. valid asserted in the frame_done cycle -> the next start bit begins on the following edge. Two complete, contiguous frames are decoded.
5. tens=4'hA -> the third byte is 3F. All other bytes are per encoding.
6. Assert rst at cycle 150 of a frame -> tx=1, busy=0, overrun=0 next cycle. A valid after release produces a clean full frame.
